// File: rtl/renode_interrupts_bridge_pkg.sv
// Shared types for the renode interrupts bridge.
//  - action_t    : Renode co-simulation message actions (interrupt included)
//  - address_t / data_t / message_t : Renode message payload
//  - index_width : width of a line index for a given line count (min 1)
//  - pack_interrupt_msg : builds the interrupt message the wrapper forwards
package renode_interrupts_bridge_pkg;

    localparam int MAX_INTERRUPTS = 1024;

    typedef enum logic [7:0] {
        ACT_INVALID       = 8'd0,
        ACT_TICK_CLOCK    = 8'd1,
        ACT_WRITE_REQUEST = 8'd2,
        ACT_READ_REQUEST  = 8'd3,
        ACT_PUSH_DATA     = 8'd4,
        ACT_GET_DATA      = 8'd5,
        ACT_RESET         = 8'd6,
        ACT_INTERRUPT     = 8'd7,
        ACT_OK            = 8'd8,
        ACT_ERROR         = 8'd9
    } action_t;

    typedef logic [63:0] address_t;
    typedef logic [63:0] data_t;

    typedef struct packed {
        action_t  action;
        address_t address;
        data_t    data;
    } message_t;

    function automatic int index_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // address carries the line index, data carries the new level
    function automatic message_t pack_interrupt_msg(input address_t index, input logic level);
        message_t m;
        m.action  = ACT_INTERRUPT;
        m.address = index;
        m.data    = data_t'(level);
        return m;
    endfunction

endpackage

// File: rtl/renode_interrupts_bridge_if.sv
// Change-message channel from the interrupts bridge to the Renode wrapper.
//  msg_valid : message presented (producer)
//  msg_ready : consumer accepts (consumer)
//  msg_index : changed line index, IW bits (producer)
//  msg_level : new level of that line (producer)
interface renode_interrupts_bridge_if #(
    parameter int IW = 1
) ();
    logic          msg_valid;
    logic          msg_ready;
    logic [IW-1:0] msg_index;
    logic          msg_level;

    modport master (
        output msg_valid,
        output msg_index,
        output msg_level,
        input  msg_ready
    );

    modport slave (
        input  msg_valid,
        input  msg_index,
        input  msg_level,
        output msg_ready
    );
endinterface

// File: rtl/renode_interrupts_bridge_rr_arbiter.sv
// Combinational round-robin picker.
//  req       : request vector, N bits
//  ptr       : search start position (0..N-1)
//  gnt_idx   : first set request at or above ptr, wrapping to 0
//  gnt_valid : any request set
module renode_interrupts_bridge_rr_arbiter
    import renode_interrupts_bridge_pkg::*;
#(
    parameter  int N  = 1,
    localparam int IW = index_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_valid
);

    logic [N-1:0]  req_hi;
    logic [IW-1:0] idx_hi;
    logic [IW-1:0] idx_all;

    // Two lowest-set-bit searches: one over requests at/above ptr, one over
    // all requests. If nothing is at/above ptr the search has wrapped.
    always_comb begin
        req_hi  = '0;
        idx_hi  = '0;
        idx_all = '0;
        for (int i = 0; i < N; i++)
            req_hi[i] = req[i] && (i >= int'(ptr));
        for (int i = N - 1; i >= 0; i--) begin
            if (req_hi[i]) idx_hi  = IW'(i);
            if (req[i])    idx_all = IW'(i);
        end
    end

    assign gnt_valid = |req;
    assign gnt_idx   = (|req_hi) ? idx_hi : idx_all;

endmodule

// File: rtl/renode_interrupts_bridge.sv
// Interrupt change reporter for the Renode co-simulation block.
// Compares the live interrupt levels against the levels Renode has been
// told and emits one {index, level} message per settled change.
//  clk        : system clock
//  rst        : synchronous, active-high reset
//  interrupts : level-sensitive interrupt lines, synchronous to clk
//  msg        : change-message channel (valid/ready/index/level)
module renode_interrupts_bridge
    import renode_interrupts_bridge_pkg::*;
#(
    parameter int InterruptsCount = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [InterruptsCount-1:0] interrupts,
    renode_interrupts_bridge_if.master msg
);

    localparam int N  = InterruptsCount;
    localparam int IW = index_width(N);

    logic [N-1:0]  reported;
    logic [N-1:0]  pend;
    logic          valid_q;
    logic [IW-1:0] index_q;
    logic          level_q;
    logic [IW-1:0] rr_ptr;

    logic [IW-1:0] gnt_idx;
    logic          gnt_valid;
    logic          gnt_level;
    logic [IW-1:0] next_ptr;
    logic          xfer;
    logic          load;

    assign xfer = valid_q & msg.msg_ready;
    assign load = ~valid_q | msg.msg_ready;

    // The held line is masked out: if it toggles while waiting, its pending
    // bit reappears once reported[] catches up after the transfer.
    always_comb begin
        pend = '0;
        for (int i = 0; i < N; i++)
            pend[i] = (interrupts[i] ^ reported[i]) & ~(valid_q && index_q == IW'(i));
    end

    renode_interrupts_bridge_rr_arbiter #(.N(N)) u_arb (
        .req       (pend),
        .ptr       (rr_ptr),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    // Level is sampled from the live line at load time, so a line that
    // flipped back already has no pending bit and is never picked.
    always_comb begin
        gnt_level = 1'b0;
        for (int i = 0; i < N; i++)
            if (gnt_idx == IW'(i)) gnt_level = interrupts[i];
        next_ptr = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reported <= '0;
            valid_q  <= 1'b0;
            index_q  <= '0;
            level_q  <= 1'b0;
            rr_ptr   <= '0;
        end else begin
            for (int i = 0; i < N; i++)
                if (xfer && index_q == IW'(i)) reported[i] <= level_q;
            if (load) begin
                if (gnt_valid) begin
                    valid_q <= 1'b1;
                    index_q <= gnt_idx;
                    level_q <= gnt_level;
                    rr_ptr  <= next_ptr;
                end else begin
                    valid_q <= 1'b0;
                end
            end
        end
    end

    assign msg.msg_valid = valid_q;
    assign msg.msg_index = index_q;
    assign msg.msg_level = level_q;

endmodule

// File: tb/tb_renode_interrupts_bridge.sv
module tb_renode_interrupts_bridge;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] irq;

    renode_interrupts_bridge_if #(.IW(2)) bus ();

    renode_interrupts_bridge #(.InterruptsCount(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .interrupts (irq),
        .msg        (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic [3:0] irq;
        logic       rdy;
        logic       v;
        logic [1:0] idx;
        logic       lvl;
    } vec_t;

    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    task automatic add(input logic r, input logic [3:0] i, input logic rdy,
                       input logic v, input logic [1:0] idx, input logic lvl);
        vec_t t;
        t.r = r; t.irq = i; t.rdy = rdy; t.v = v; t.idx = idx; t.lvl = lvl;
        tbl.push_back(t);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        // test 1: idle after reset
        add(0, 4'b0000, 1, 0, 0, 0);
        add(0, 4'b0000, 1, 0, 0, 0);
        add(0, 4'b0000, 1, 0, 0, 0);
        // test 2: single change on line 2
        add(0, 4'b0100, 1, 1, 2, 1);
        add(0, 4'b0100, 1, 0, 0, 0);
        add(0, 4'b0100, 1, 0, 0, 0);
        // test 3: reset (rr_ptr=0), then three lines at once
        add(1, 4'b0000, 1, 0, 0, 0);
        add(0, 4'b1011, 1, 1, 0, 1);
        add(0, 4'b1011, 1, 1, 1, 1);
        add(0, 4'b1011, 1, 1, 3, 1);
        add(0, 4'b1011, 1, 0, 0, 0);
        // test 4: held (2,1), line 2 glitches 0 and back
        add(0, 4'b1111, 0, 1, 2, 1);
        add(0, 4'b1011, 0, 1, 2, 1);
        add(0, 4'b1111, 0, 1, 2, 1);
        add(0, 4'b1111, 1, 0, 0, 0);
        add(0, 4'b1111, 1, 0, 0, 0);
        // test 5: held (1,1), line 1 drops -> follow-up (1,0)
        add(0, 4'b1101, 1, 1, 1, 0);
        add(0, 4'b1101, 1, 0, 0, 0);
        add(0, 4'b1111, 0, 1, 1, 1);
        add(0, 4'b1101, 0, 1, 1, 1);
        add(0, 4'b1101, 1, 0, 0, 0);
        add(0, 4'b1101, 1, 1, 1, 0);
        add(0, 4'b1101, 1, 0, 0, 0);
        // test 6: reset while a message is held, message reissued
        add(1, 4'b0001, 0, 0, 0, 0);
        add(0, 4'b0001, 0, 1, 0, 1);
        add(0, 4'b0001, 0, 1, 0, 1);
        add(1, 4'b0001, 0, 0, 0, 0);
        add(1, 4'b0001, 0, 0, 0, 0);
        add(0, 4'b0001, 0, 1, 0, 1);
        add(0, 4'b0001, 1, 0, 0, 0);
        // all four change, order wraps from rr_ptr=1 back to 0
        add(0, 4'b1110, 1, 1, 1, 1);
        add(0, 4'b1110, 1, 1, 2, 1);
        add(0, 4'b1110, 1, 1, 3, 1);
        add(0, 4'b1110, 1, 1, 0, 0);
        add(0, 4'b1110, 1, 0, 0, 0);
        // glitch on line 3 while line 0 is held: no message for line 3
        add(0, 4'b1111, 0, 1, 0, 1);
        add(0, 4'b0111, 0, 1, 0, 1);
        add(0, 4'b1111, 0, 1, 0, 1);
        add(0, 4'b1111, 1, 0, 0, 0);
        add(0, 4'b1111, 1, 0, 0, 0);

        rst = 1'b1;
        irq = 4'b0000;
        bus.msg_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", int'(bus.msg_valid), 0);
        chk("reset_index", int'(bus.msg_index), 0);
        chk("reset_level", int'(bus.msg_level), 0);
        rst = 1'b0;

        for (int k = 0; k < tbl.size(); k++) begin
            rst = tbl[k].r;
            irq = tbl[k].irq;
            bus.msg_ready = tbl[k].rdy;
            @(posedge clk);
            #1;
            chk($sformatf("row%0d_valid", k), int'(bus.msg_valid), int'(tbl[k].v));
            if (tbl[k].v) begin
                chk($sformatf("row%0d_index", k), int'(bus.msg_index), int'(tbl[k].idx));
                chk($sformatf("row%0d_level", k), int'(bus.msg_level), int'(tbl[k].lvl));
            end
        end

        // lines already high at reset are reported as level 1, in order
        begin
            int n = 0;
            int seen[$];
            rst = 1'b1;
            irq = 4'b1010;
            bus.msg_ready = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            for (int c = 0; c < 10; c++) begin
                @(posedge clk);
                #1;
                if (bus.msg_valid) begin
                    n++;
                    seen.push_back(int'(bus.msg_index) * 2 + int'(bus.msg_level));
                end
            end
            chk("drain_count", n, 2);
            if (seen.size() >= 2) begin
                chk("drain_first", seen[0], 1 * 2 + 1);
                chk("drain_second", seen[1], 3 * 2 + 1);
            end else begin
                chk("drain_seen", seen.size(), 2);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
